// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the decode-stage issue scoreboard: register-file geometry,
// FSM encoding, opcode constants and small decode helpers.
package issue_scoreboard_pkg;

    localparam int NREG       = 16;
    localparam int AW         = 4;
    localparam int WB_LAT_DEF = 3;
    localparam int TMR_W      = 3;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } sb_state_e;

    localparam logic [3:0] OPC_NOP = 4'h0;
    localparam logic [3:0] OPC_JMP = 4'hC;

    // One-hot select of a register index.
    function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] addr);
        return {{(NREG-1){1'b0}}, 1'b1} << addr;
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/writeback request bundle and scoreboard status returned to decode/fetch.
interface issue_scoreboard_if #(
    parameter int AW   = 4,
    parameter int NREG = 16,
    parameter int CNTW = 16
);
    logic            dec_valid;
    logic [AW-1:0]   dec_ra;
    logic [AW-1:0]   dec_rb;
    logic            dec_use_b;
    logic [AW-1:0]   dec_rd;
    logic            dec_wr;
    logic            dec_jump;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic            stall;
    logic            flush;
    logic            issue_ok;
    logic [NREG-1:0] busy_mask;
    logic [CNTW-1:0] stall_cnt;
    logic            sb_err;

    modport master (
        output dec_valid, dec_ra, dec_rb, dec_use_b, dec_rd, dec_wr, dec_jump,
        output wb_valid, wb_addr,
        input  stall, flush, issue_ok, busy_mask, stall_cnt, sb_err
    );

    modport slave (
        input  dec_valid, dec_ra, dec_rb, dec_use_b, dec_rd, dec_wr, dec_jump,
        input  wb_valid, wb_addr,
        output stall, flush, issue_ok, busy_mask, stall_cnt, sb_err
    );
endinterface

// File: rtl/issue_scoreboard_timer.sv
// Countdown for one architectural register: load wins over decrement, busy while nonzero.
module sb_timer
    import issue_scoreboard_pkg::*;
#(
    parameter int LAT = WB_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    output logic [TMR_W-1:0] cnt_o,
    output logic             busy_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             busy_q;

    // Next count value.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = TMR_W'(LAT);
        end else if (dec_i && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count and busy flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= 3'd0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != 3'd0);
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-stage scoreboard: per-register write timers, RAW interlock, jump flush
// sequencing, stall performance counter and sticky writeback-consistency error.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int WB_LAT    = WB_LAT_DEF,
    parameter int FLUSH_CYC = 1,
    parameter int CNTW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    issue_scoreboard_if.slave sb
);

    logic [NREG-1:0]  load_s;
    logic [NREG-1:0]  busy_s;
    logic [TMR_W-1:0] cnt_s [NREG];

    sb_state_e        state_q, state_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic             flush_q;
    logic [CNTW-1:0]  stall_cnt_q;
    logic             sb_err_q;

    logic             run_s, raw_s, stall_s, issue_s, wb_ok_s;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_tmr
            sb_timer #(.LAT(WB_LAT)) u_tmr (
                .clk    (clk),
                .rst    (rst),
                .load_i (load_s[gi]),
                .dec_i  (1'b1),
                .cnt_o  (cnt_s[gi]),
                .busy_o (busy_s[gi])
            );
        end
    endgenerate

    // Hazard qualification; ra==rb simply reads the same busy bit twice.
    always_comb begin
        run_s   = (state_q == S_RUN);
        raw_s   = busy_s[sb.dec_ra] | (sb.dec_use_b & busy_s[sb.dec_rb]);
        stall_s = sb.dec_valid & raw_s & run_s;
        issue_s = sb.dec_valid & ~raw_s & run_s;
        load_s  = {NREG{issue_s & sb.dec_wr}} & reg_onehot(sb.dec_rd);
        // A writeback is consistent on the final timer cycle or when the register is being reloaded.
        wb_ok_s = (cnt_s[sb.wb_addr] == 3'd1) | load_s[sb.wb_addr];
    end

    // Run/flush sequencer next state.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_RUN: begin
                if (issue_s && sb.dec_jump) begin
                    state_d = S_FLUSH;
                    fcnt_d  = 2'(FLUSH_CYC - 1);
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (fcnt_q == 2'd0) begin
                    state_d = S_RUN;
                end else begin
                    fcnt_d  = fcnt_q - 2'd1;
                end
            end
            default: begin
                state_d = S_RUN;
                fcnt_d  = 2'd0;
            end
        endcase
    end

    // Sequencer, flush, counter and error registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_RUN;
            fcnt_q      <= 2'd0;
            flush_q     <= 1'b0;
            stall_cnt_q <= {CNTW{1'b0}};
            sb_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            flush_q <= (state_d == S_FLUSH);
            if (stall_s && (stall_cnt_q != {CNTW{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
            end
            if (sb.wb_valid && !wb_ok_s) begin
                sb_err_q <= 1'b1;
            end
        end
    end

    assign sb.stall     = stall_s;
    assign sb.issue_ok  = issue_s;
    assign sb.flush     = flush_q;
    assign sb.busy_mask = busy_s;
    assign sb.stall_cnt = stall_cnt_q;
    assign sb.sb_err    = sb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios plus randomized traffic checked
// against a cycle-stamp reference model (ready cycle per register, flush window).
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    localparam int LAT  = 3;
    localparam int FC   = 1;
    localparam int CW   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_scoreboard_if #(.AW(4), .NREG(16), .CNTW(CW)) bus ();

    issue_scoreboard #(.WB_LAT(LAT), .FLUSH_CYC(FC), .CNTW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: register r is pending in cycles cyc < ready_at[r];
    // flush is asserted in cycles cyc <= flush_end.
    int cyc = 0;
    int ready_at [16];
    int flush_end = -1;
    int scnt = 0;
    bit err = 1'b0;

    function automatic bit m_busy(input int r);
        return cyc < ready_at[r];
    endfunction

    function automatic logic [15:0] m_mask();
        logic [15:0] m;
        for (int r = 0; r < 16; r++) m[r] = m_busy(r);
        return m;
    endfunction

    function automatic bit m_flush();
        return cyc <= flush_end;
    endfunction

    function automatic bit m_raw();
        return m_busy(int'(bus.dec_ra)) || (bus.dec_use_b && m_busy(int'(bus.dec_rb)));
    endfunction

    function automatic bit m_stall();
        return bus.dec_valid && m_raw() && !m_flush();
    endfunction

    function automatic bit m_issue();
        return bus.dec_valid && !m_raw() && !m_flush();
    endfunction

    task automatic tick();
        bit st, is, legal;
        st = m_stall();
        is = m_issue();
        @(posedge clk);
        if (!rst) begin
            for (int r = 0; r < 16; r++) ready_at[r] = 0;
            flush_end = -1;
            scnt = 0;
            err = 1'b0;
        end else begin
            if (st && scnt < (1 << CW) - 1) scnt++;
            if (bus.wb_valid) begin
                legal = (m_busy(int'(bus.wb_addr)) && cyc == ready_at[bus.wb_addr] - 1) ||
                        (is && bus.dec_wr && bus.dec_rd == bus.wb_addr);
                if (!legal) err = 1'b1;
            end
            if (is && bus.dec_wr) ready_at[bus.dec_rd] = cyc + 1 + LAT;
            if (is && bus.dec_jump) flush_end = cyc + FC;
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        bus.dec_valid = 1'b0; bus.dec_ra = 4'd0; bus.dec_rb = 4'd0; bus.dec_use_b = 1'b0;
        bus.dec_rd = 4'd0; bus.dec_wr = 1'b0; bus.dec_jump = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_addr = 4'd0;
    endtask

    task automatic set_dec(input logic [3:0] ra, input logic [3:0] rb, input logic ub,
                           input logic [3:0] rd, input logic wr, input logic jp);
        bus.dec_valid = 1'b1; bus.dec_ra = ra; bus.dec_rb = rb; bus.dec_use_b = ub;
        bus.dec_rd = rd; bus.dec_wr = wr; bus.dec_jump = jp;
    endtask

    task automatic test_reset();
        rst = 1'b0; idle();
        tick(); tick();
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.busy_mask !== 16'h0) begin n_fail++; $display("FAIL reset_busy got %h want 0000", bus.busy_mask); end
        n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", bus.flush); end
        n_chk++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bus.stall_cnt); end
        n_chk++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.sb_err); end
        n_chk++; if (bus.stall !== 1'b0 || bus.issue_ok !== 1'b0) begin n_fail++; $display("FAIL reset_idle got stall=%b ok=%b want 0 0", bus.stall, bus.issue_ok); end
        tick();
    endtask

    task automatic test_raw_stall();
        set_dec(4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        @(negedge clk);
        n_chk++; if (bus.issue_ok !== 1'b1) begin n_fail++; $display("FAIL raw_prod_issue got %b want 1", bus.issue_ok); end
        tick();
        set_dec(4'd3, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++; if (bus.stall !== 1'b1 || bus.issue_ok !== 1'b0) begin n_fail++; $display("FAIL raw_stall[%0d] got stall=%b ok=%b want 1 0", k, bus.stall, bus.issue_ok); end
            tick();
        end
        @(negedge clk);
        n_chk++; if (bus.stall !== 1'b0 || bus.issue_ok !== 1'b1) begin n_fail++; $display("FAIL raw_release got stall=%b ok=%b want 0 1", bus.stall, bus.issue_ok); end
        n_chk++; if (bus.stall_cnt !== 16'd3) begin n_fail++; $display("FAIL raw_cnt got %0d want 3", bus.stall_cnt); end
        tick();
        idle();
    endtask

    task automatic test_imm();
        set_dec(4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        tick();
        set_dec(4'd1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        n_chk++; if (bus.stall !== 1'b0 || bus.issue_ok !== 1'b1) begin n_fail++; $display("FAIL imm_form got stall=%b ok=%b want 0 1", bus.stall, bus.issue_ok); end
        tick();
        idle();
        for (int k = 0; k < LAT; k++) tick();
    endtask

    task automatic test_jump();
        set_dec(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        n_chk++; if (bus.issue_ok !== 1'b1 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL jump_issue got ok=%b flush=%b want 1 0", bus.issue_ok, bus.flush); end
        tick();
        set_dec(4'd1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        n_chk++; if (bus.flush !== 1'b1 || bus.issue_ok !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL jump_flush got flush=%b ok=%b stall=%b want 1 0 0", bus.flush, bus.issue_ok, bus.stall); end
        tick();
        @(negedge clk);
        n_chk++; if (bus.flush !== 1'b0 || bus.issue_ok !== 1'b1) begin n_fail++; $display("FAIL jump_run got flush=%b ok=%b want 0 1", bus.flush, bus.issue_ok); end
        tick();
        idle();
    endtask

    task automatic test_waw();
        set_dec(4'd0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        n_chk++; if (bus.busy_mask[5] !== 1'b1) begin n_fail++; $display("FAIL waw_t1 got %b want 1", bus.busy_mask[5]); end
        tick();
        idle();
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            n_chk++; if (bus.busy_mask[5] !== 1'b1) begin n_fail++; $display("FAIL waw_t%0d got %b want 1", k, bus.busy_mask[5]); end
            tick();
        end
        @(negedge clk);
        n_chk++; if (bus.busy_mask[5] !== 1'b0) begin n_fail++; $display("FAIL waw_t5 got %b want 0", bus.busy_mask[5]); end
        tick();
    endtask

    task automatic test_sb_err();
        idle();
        bus.wb_valid = 1'b1; bus.wb_addr = 4'd7;
        @(negedge clk);
        n_chk++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL err_before got %b want 0", bus.sb_err); end
        tick();
        bus.wb_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++; if (bus.sb_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky[%0d] got %b want 1", k, bus.sb_err); end
            tick();
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got %b want 0", bus.sb_err); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_dec(4'd0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        tick();
        set_dec(4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        set_dec(4'd0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
        tick();
        idle();
        @(negedge clk);
        n_chk++; if (bus.flush !== 1'b1 || bus.busy_mask[2:1] !== 2'b11 || bus.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_pre got flush=%b busy=%b cnt=%0d want 1 11 1", bus.flush, bus.busy_mask[2:1], bus.stall_cnt); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_dec(4'd1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        n_chk++; if (bus.busy_mask !== 16'h0 || bus.flush !== 1'b0 || bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_post got busy=%h flush=%b cnt=%0d want 0000 0 0", bus.busy_mask, bus.flush, bus.stall_cnt); end
        n_chk++; if (bus.issue_ok !== 1'b1 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL mid_issue got ok=%b stall=%b want 1 0", bus.issue_ok, bus.stall); end
        tick();
        idle();
    endtask

    task automatic test_random();
        int wr_reg;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) != 0);
            bus.dec_valid = ($urandom_range(0, 3) != 0);
            bus.dec_ra    = 4'($urandom_range(0, 7));
            bus.dec_rb    = ($urandom_range(0, 3) == 0) ? bus.dec_ra : 4'($urandom_range(0, 7));
            bus.dec_use_b = 1'($urandom_range(0, 1));
            bus.dec_rd    = 4'($urandom_range(0, 7));
            bus.dec_wr    = ($urandom_range(0, 2) != 0);
            bus.dec_jump  = ($urandom_range(0, 9) == 0);
            bus.wb_valid  = 1'b0;
            bus.wb_addr   = 4'($urandom_range(0, 15));
            wr_reg = -1;
            for (int r = 0; r < 16; r++) if (m_busy(r) && cyc == ready_at[r] - 1) wr_reg = r;
            if (wr_reg >= 0 && $urandom_range(0, 3) != 0) begin
                bus.wb_valid = 1'b1; bus.wb_addr = 4'(wr_reg);
            end else if (m_issue() && bus.dec_wr && $urandom_range(0, 3) == 0) begin
                bus.wb_valid = 1'b1; bus.wb_addr = bus.dec_rd;
            end
            @(negedge clk);
            n_chk++; if (bus.stall !== m_stall() || bus.issue_ok !== m_issue()) begin n_fail++; $display("FAIL rnd_hazard cyc %0d got stall=%b ok=%b want %b %b", cyc, bus.stall, bus.issue_ok, m_stall(), m_issue()); end
            n_chk++; if (bus.busy_mask !== m_mask() || bus.flush !== m_flush()) begin n_fail++; $display("FAIL rnd_state cyc %0d got busy=%h flush=%b want %h %b", cyc, bus.busy_mask, bus.flush, m_mask(), m_flush()); end
            n_chk++; if (bus.stall_cnt !== 16'(scnt) || bus.sb_err !== err) begin n_fail++; $display("FAIL rnd_cnt cyc %0d got cnt=%0d err=%b want %0d %b", cyc, bus.stall_cnt, bus.sb_err, scnt, err); end
            tick();
        end
        rst = 1'b1;
        idle();
    endtask

    initial begin
        for (int r = 0; r < 16; r++) ready_at[r] = 0;
        rst = 1'b0;
        idle();
        #1;
        test_reset();
        test_raw_stall();
        test_imm();
        test_jump();
        test_waw();
        test_sb_err();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
